universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
Parametrised successor to the team's fixed 4-bit serial-in/serial-out shift register.
- Adds selectable width, bidirectional shift, rotate, parallel load/read, clock enable and synchronous reset.
- Adds a shift counter that flags each completed word, so the block serves as a serializer/deserializer front-end in the mini-project datapaths.
- With WIDTH=4 and mode SHL, data movement is identical to the legacy block: serial bit enters at LSB and moves toward MSB.

Parameters:
WIDTH, 8, register length in bits; legal range WIDTH >= 2.
RESET_VALUE, {WIDTH{1'b0}}, contents loaded into the register on reset.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
enable  input  1  when 0, all state holds regardless of mode.
mode  input  3  operation select; encodings listed under Behaviour.
serial_in_lsb  input  1  bit entering at bit 0 during SHL.
serial_in_msb  input  1  bit entering at bit WIDTH-1 during SHR.
parallel_in  input  WIDTH  word captured by LOAD.
parallel_out  output  WIDTH  current register contents (bits).
shift_out  output  1  registered copy of the last bit shifted or rotated out.
shift_count  output  CW  shifts since last LOAD/reset/wrap; CW = $clog2(WIDTH+1).
word_done  output  1  one-cycle pulse after the WIDTH-th shift.

Behaviour:
- Reset values (RST=1 at a rising edge): bits=RESET_VALUE, shift_out=0, shift_count=0, word_done=0.
- Priority at each edge: RST, then enable=0, then mode. RST overrides enable and mode, and aborts any partially shifted word.
- With enable=0, bits, shift_out and shift_count all hold, and word_done=0.
- Mode encodings, applied when enable=1:
  - 000 HOLD: everything holds; word_done=0.
  - 001 SHL: bits <= {bits[W-2:0], serial_in_lsb}; shift_out <= bits[W-1].
  - 010 SHR: bits <= {serial_in_msb, bits[W-1:1]}; shift_out <= bits[0].
  - 011 ROL: bits <= {bits[W-2:0], bits[W-1]}; shift_out <= bits[W-1].
  - 100 ROR: bits <= {bits[0], bits[W-1:1]}; shift_out <= bits[0].
  - 101 LOAD: bits <= parallel_in; shift_count <= 0; shift_out holds; word_done=0.
  - 110, 111: reserved; behave exactly as HOLD.
- Shift ops (SHL/SHR/ROL/ROR) increment shift_count.
  - On the shift where shift_count==WIDTH-1, shift_count wraps to 0 and word_done=1 in the following cycle only.
  - Mixing directions within one word still counts every shift.
- Latency: every output is registered and changes one edge after the command. parallel_out is combinationally equal to bits.
- No X propagation: serial inputs feed only the shift paths that use them.

Decomposition:
- Package usr_pkg holds:
  - mode localparams: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD;
  - a function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- One sub-module, shift_word_counter, holds shift_count and generates word_done.
  - Inputs: CLK, RST, clear (=LOAD), step (=shift op & enable).
  - Parameter: WIDTH.
- The datapath mux and register stay in the top module.

Test Plan:
1. WIDTH=4, RST=1 for one edge, then mode=SHL, serial_in_lsb=0 for 4 edges -> bits=0000. Then serial_in_lsb=1: after 2 edges bits=0011, after 4 edges bits=1111 (legacy compatibility).
2. WIDTH=8, LOAD 0xA5, then 8 x SHL with serial_in_lsb=0 -> shift_out sequence 1,0,1,0,0,1,0,1. word_done=1 only in the cycle after the 8th shift, shift_count=0, bits=0x00.
3. WIDTH=8, LOAD 0x81, then ROR x1 -> 0xC0, shift_out=1. Then ROL x2 -> 0x03. shift_count=3.
4. WIDTH=8, LOAD 0x0F, SHR x3 with serial_in_msb=1, enable=0 for 2 cycles, SHR x1 -> bits hold during the enable=0 cycles. Final bits=0xF0, shift_count=4, word_done never asserted.
5. Run 5 SHL, then assert RST with mode=LOAD and enable=1 -> bits=RESET_VALUE, shift_count=0, shift_out=0. The next 8 shifts produce word_done after the 8th, not the 3rd.
6. mode=110/111 with enable=1 for 3 cycles after LOAD 0x3C -> bits=0x3C, shift_count=0, word_done=0 throughout.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode encodings and sizing helper for the universal shift register.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  // Wide enough to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control and data bundle of the universal shift register; master drives commands.
interface universal_shift_register_if #(
  parameter int WIDTH = 8
);
  localparam int CW = usr_pkg::cnt_width(WIDTH);

  logic             enable;
  logic [2:0]       mode;
  logic             serial_in_lsb;
  logic             serial_in_msb;
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] parallel_out;
  logic             shift_out;
  logic [CW-1:0]    shift_count;
  logic             word_done;

  modport master (
    output enable, mode, serial_in_lsb, serial_in_msb, parallel_in,
    input  parallel_out, shift_out, shift_count, word_done
  );

  modport slave (
    input  enable, mode, serial_in_lsb, serial_in_msb, parallel_in,
    output parallel_out, shift_out, shift_count, word_done
  );

endinterface

// File: rtl/shift_word_counter.sv
// Counts shifts within a word and pulses word_done for one cycle after each full word.
module shift_word_counter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] shift_count,
  output logic          word_done
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_count <= '0;
      word_done   <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (clear) begin
        shift_count <= '0;
      end else if (step) begin
        // The last shift of a word wraps the count and raises the pulse together.
        if (shift_count == CW'(WIDTH - 1)) begin
          shift_count <= '0;
          word_done   <= 1'b1;
        end else begin
          shift_count <= shift_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised bidirectional shift/rotate register with parallel load and word counter.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      CLK,
  input  logic                      RST,
  universal_shift_register_if.slave bus
);

  logic [WIDTH-1:0] bits;
  logic             shift_out_q;
  logic             shift_op;
  logic             load_op;

  assign shift_op = bus.enable && (bus.mode inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR});
  assign load_op  = bus.enable && (bus.mode == MODE_LOAD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      bits        <= RESET_VALUE;
      shift_out_q <= 1'b0;
    end else if (bus.enable) begin
      // Reserved encodings fall through to the default and hold like HOLD.
      case (bus.mode)
        MODE_SHL: begin
          bits        <= {bits[WIDTH-2:0], bus.serial_in_lsb};
          shift_out_q <= bits[WIDTH-1];
        end
        MODE_SHR: begin
          bits        <= {bus.serial_in_msb, bits[WIDTH-1:1]};
          shift_out_q <= bits[0];
        end
        MODE_ROL: begin
          bits        <= {bits[WIDTH-2:0], bits[WIDTH-1]};
          shift_out_q <= bits[WIDTH-1];
        end
        MODE_ROR: begin
          bits        <= {bits[0], bits[WIDTH-1:1]};
          shift_out_q <= bits[0];
        end
        MODE_LOAD: begin
          bits <= bus.parallel_in;
        end
        default: begin
          bits        <= bits;
          shift_out_q <= shift_out_q;
        end
      endcase
    end
  end

  shift_word_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .CLK         (CLK),
    .RST         (RST),
    .clear       (load_op),
    .step        (shift_op),
    .shift_count (bus.shift_count),
    .word_done   (bus.word_done)
  );

  assign bus.parallel_out = bits;
  assign bus.shift_out    = shift_out_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: directed commands queue hand-computed results, a monitor checks them.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic CLK_tb = 1'b0;
  logic RST    = 1'b0;

  always #5 CLK_tb = ~CLK_tb;

  universal_shift_register_if #(.WIDTH(8)) bus8 ();
  universal_shift_register_if #(.WIDTH(4)) bus4 ();

  universal_shift_register #(.WIDTH(8)) dut8 (
    .CLK (CLK_tb),
    .RST (RST),
    .bus (bus8)
  );

  universal_shift_register #(.WIDTH(4)) dut4 (
    .CLK (CLK_tb),
    .RST (RST),
    .bus (bus4)
  );

  typedef struct {
    bit          sel4;
    logic [7:0]  bits;
    logic        so;
    logic [3:0]  cnt;
    logic        wd;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total_checks  = 0;
  int   passed_checks = 0;

  task automatic checkOutput(input exp_t e);
    logic [7:0] act_bits;
    logic       act_so;
    logic [3:0] act_cnt;
    logic       act_wd;
    if (e.sel4) begin
      act_bits = {4'b0000, bus4.parallel_out};
      act_so   = bus4.shift_out;
      act_cnt  = {1'b0, bus4.shift_count};
      act_wd   = bus4.word_done;
    end else begin
      act_bits = bus8.parallel_out;
      act_so   = bus8.shift_out;
      act_cnt  = bus8.shift_count;
      act_wd   = bus8.word_done;
    end
    total_checks++;
    if (act_bits !== e.bits || act_so !== e.so || act_cnt !== e.cnt || act_wd !== e.wd)
      $display("[TB] FAIL %s: got bits=%h so=%b cnt=%0d wd=%b, want bits=%h so=%b cnt=%0d wd=%b",
               e.name, act_bits, act_so, act_cnt, act_wd, e.bits, e.so, e.cnt, e.wd);
    else
      passed_checks++;
  endtask

  // Each queued entry describes the state right after the edge that consumed its command.
  always @(negedge CLK_tb) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic applyStimulus(input bit sel4, input logic rst, input logic en,
                               input logic [2:0] md, input logic sl, input logic sm,
                               input logic [7:0] pin, input logic [7:0] eb,
                               input logic eso, input logic [3:0] ec, input logic ewd,
                               input string nm);
    exp_t e;
    @(negedge CLK_tb);
    RST                = rst;
    bus8.enable        = en;
    bus8.mode          = md;
    bus8.serial_in_lsb = sl;
    bus8.serial_in_msb = sm;
    bus8.parallel_in   = pin;
    bus4.enable        = en;
    bus4.mode          = md;
    bus4.serial_in_lsb = sl;
    bus4.serial_in_msb = sm;
    bus4.parallel_in   = pin[3:0];
    @(posedge CLK_tb);
    #1;
    e.sel4 = sel4;
    e.bits = eb;
    e.so   = eso;
    e.cnt  = ec;
    e.wd   = ewd;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    bus8.enable = 1'b0; bus8.mode = MODE_HOLD; bus8.serial_in_lsb = 1'b0;
    bus8.serial_in_msb = 1'b0; bus8.parallel_in = '0;
    bus4.enable = 1'b0; bus4.mode = MODE_HOLD; bus4.serial_in_lsb = 1'b0;
    bus4.serial_in_msb = 1'b0; bus4.parallel_in = '0;

    // Legacy 4-bit compatibility
    applyStimulus(1, 1, 1, MODE_HOLD, 0, 0, 8'h00, 8'h00, 0, 0, 0, "w4_reset");
    applyStimulus(1, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 1, 0, "w4_shl0_1");
    applyStimulus(1, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 2, 0, "w4_shl0_2");
    applyStimulus(1, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 3, 0, "w4_shl0_3");
    applyStimulus(1, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 0, 1, "w4_shl0_4");
    applyStimulus(1, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h01, 0, 1, 0, "w4_shl1_1");
    applyStimulus(1, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h03, 0, 2, 0, "w4_shl1_2");
    applyStimulus(1, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h07, 0, 3, 0, "w4_shl1_3");
    applyStimulus(1, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h0F, 0, 0, 1, "w4_shl1_4");

    // Serialize 0xA5 MSB-first
    applyStimulus(0, 1, 1, MODE_HOLD, 0, 0, 8'h00, 8'h00, 0, 0, 0, "w8_reset");
    applyStimulus(0, 0, 1, MODE_LOAD, 0, 0, 8'hA5, 8'hA5, 0, 0, 0, "load_a5");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h4A, 1, 1, 0, "ser_1");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h94, 0, 2, 0, "ser_2");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h28, 1, 3, 0, "ser_3");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h50, 0, 4, 0, "ser_4");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'hA0, 0, 5, 0, "ser_5");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h40, 1, 6, 0, "ser_6");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h80, 0, 7, 0, "ser_7");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h00, 1, 0, 1, "ser_8_done");
    applyStimulus(0, 0, 1, MODE_HOLD, 0, 0, 8'h00, 8'h00, 1, 0, 0, "done_one_cycle");

    // Rotates in both directions
    applyStimulus(0, 0, 1, MODE_LOAD, 0, 0, 8'h81, 8'h81, 1, 0, 0, "load_81");
    applyStimulus(0, 0, 1, MODE_ROR,  0, 0, 8'h00, 8'hC0, 1, 1, 0, "ror_1");
    applyStimulus(0, 0, 1, MODE_ROL,  0, 0, 8'h00, 8'h81, 1, 2, 0, "rol_1");
    applyStimulus(0, 0, 1, MODE_ROL,  0, 0, 8'h00, 8'h03, 1, 3, 0, "rol_2");

    // Right shifts with enable gaps; LOAD mid-word clears the count
    applyStimulus(0, 0, 1, MODE_LOAD, 0, 0, 8'h0F, 8'h0F, 1, 0, 0, "load_0f");
    applyStimulus(0, 0, 1, MODE_SHR,  0, 1, 8'h00, 8'h87, 1, 1, 0, "shr_1");
    applyStimulus(0, 0, 1, MODE_SHR,  0, 1, 8'h00, 8'hC3, 1, 2, 0, "shr_2");
    applyStimulus(0, 0, 1, MODE_SHR,  0, 1, 8'h00, 8'hE1, 1, 3, 0, "shr_3");
    applyStimulus(0, 0, 0, MODE_SHR,  0, 1, 8'h00, 8'hE1, 1, 3, 0, "en0_1");
    applyStimulus(0, 0, 0, MODE_SHR,  0, 1, 8'h00, 8'hE1, 1, 3, 0, "en0_2");
    applyStimulus(0, 0, 1, MODE_SHR,  0, 1, 8'h00, 8'hF0, 1, 4, 0, "shr_4");

    // Reset aborts a partial word and wins over LOAD
    applyStimulus(0, 0, 1, MODE_LOAD, 0, 0, 8'hFF, 8'hFF, 1, 0, 0, "load_ff");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'hFE, 1, 1, 0, "part_1");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'hFC, 1, 2, 0, "part_2");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'hF8, 1, 3, 0, "part_3");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'hF0, 1, 4, 0, "part_4");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'hE0, 1, 5, 0, "part_5");
    applyStimulus(0, 1, 1, MODE_LOAD, 0, 0, 8'h55, 8'h00, 0, 0, 0, "rst_over_load");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h01, 0, 1, 0, "post_rst_1");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h03, 0, 2, 0, "post_rst_2");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h07, 0, 3, 0, "post_rst_3");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h0F, 0, 4, 0, "post_rst_4");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h1F, 0, 5, 0, "post_rst_5");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h3F, 0, 6, 0, "post_rst_6");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'h7F, 0, 7, 0, "post_rst_7");
    applyStimulus(0, 0, 1, MODE_SHL,  1, 0, 8'h00, 8'hFF, 0, 0, 1, "post_rst_8");

    // Reserved encodings hold; then HOLD keeps a nonzero count
    applyStimulus(0, 0, 1, MODE_LOAD, 0, 0, 8'h3C, 8'h3C, 0, 0, 0, "load_3c");
    applyStimulus(0, 0, 1, 3'b110,    1, 1, 8'hFF, 8'h3C, 0, 0, 0, "rsvd110_1");
    applyStimulus(0, 0, 1, 3'b110,    1, 1, 8'hFF, 8'h3C, 0, 0, 0, "rsvd110_2");
    applyStimulus(0, 0, 1, 3'b111,    1, 1, 8'hFF, 8'h3C, 0, 0, 0, "rsvd111");
    applyStimulus(0, 0, 1, MODE_SHL,  0, 0, 8'h00, 8'h78, 0, 1, 0, "shl_after_rsvd");
    applyStimulus(0, 0, 1, MODE_HOLD, 1, 1, 8'hFF, 8'h78, 0, 1, 0, "hold_count");

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK_tb);
    end
    if (exp_q.size() != 0) begin
      total_checks++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
